mem_dados_ctx: RTL and testbench

Parametrised data memory with per-process PC context save. It sits beside the processor datapath on the MEM stage and provides synchronous word read/write with registered read data and address-range checking. It also holds a bank of saved-PC slots, one per process, written by a small save FSM whenever the program ends or a context switch is requested outside the OS region.

---
 rtl/mem_dados_pkg.sv | 17 +
 rtl/mem_dados_ram.sv | 30 +++
 rtl/mem_dados_ctx.sv | 149 ++++++++++++++
 tb/tb_mem_dados_ctx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_dados_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dados_pkg : shared types/constants for the data memory + ctx save |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_dados_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SALVA  = 2'd1,
    PRONTO = 2'd2
  } ctx_state_e;

  localparam int unsigned OS_LIMIT_DEF = 687;

endpackage
`default_nettype wire

// File: rtl/mem_dados_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dados_ram : single-port synchronous RAM, write-first, no reset   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_dados_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read data only updates on a read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= we ? wdata : mem[addr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_dados_ctx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dados_ctx : data memory with range check and per-process PC save |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_dados_ctx
  import mem_dados_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_PROC = 4,
  parameter int OS_LIMIT = OS_LIMIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_write,
  input  logic                        mem_read,
  input  logic [31:0]                 posicao,
  input  logic [DATA_W-1:0]           dados,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        addr_err,
  input  logic [DATA_W-1:0]           pos_atual,
  input  logic [DATA_W-1:0]           end_atual,
  input  logic [$clog2(NUM_PROC)-1:0] proc_id,
  input  logic                        troca,
  input  logic                        fim,
  input  logic [$clog2(NUM_PROC)-1:0] proc_sel,
  output logic [DATA_W-1:0]           saida_pc,
  output logic [NUM_PROC-1:0]         slot_valido,
  output logic [NUM_PROC-1:0]         proc_fim,
  output logic                        ctx_ocupado,
  output logic                        ctx_pronto
);

  localparam int PW = $clog2(NUM_PROC);

  // ---------------- memory path ----------------
  logic              acc_ok, ram_we, ram_re;
  logic              rd_valid_d, rd_valid_q;
  logic              addr_err_d, addr_err_q;
  logic              has_rd_d, has_rd_q;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    acc_ok     = (posicao >> ADDR_W) == 32'd0;
    ram_we     = mem_write & acc_ok;
    ram_re     = mem_read & acc_ok;
    rd_valid_d = ram_re;
    addr_err_d = (mem_read | mem_write) & ~acc_ok;
    has_rd_d   = has_rd_q | ram_re;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      has_rd_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      has_rd_q   <= has_rd_d;
    end
  end

  mem_dados_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (posicao[ADDR_W-1:0]),
    .wdata (dados),
    .rdata (ram_rdata)
  );

  // The RAM has no reset; mask its output to 0 until the first read lands.
  assign rd_data  = has_rd_q ? ram_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

  // ---------------- context save path ----------------
  ctx_state_e        state_q;
  logic [DATA_W-1:0] pc_q;
  logic [PW-1:0]     id_q;
  logic              fim_q;
  logic [DATA_W-1:0] slot_q [NUM_PROC];
  logic [NUM_PROC-1:0] slot_valido_q, proc_fim_q;
  logic              ctx_pronto_q, ctx_ocupado_q;
  logic              save_req, accept;

  always_comb begin
    save_req = fim | (troca & (pos_atual > DATA_W'(OS_LIMIT)));
    accept   = (state_q == IDLE) & save_req & (32'(proc_id) < NUM_PROC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      id_q          <= '0;
      fim_q         <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) slot_q[i] <= '0;
      slot_valido_q <= '0;
      proc_fim_q    <= '0;
      ctx_pronto_q  <= 1'b0;
      ctx_ocupado_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ctx_pronto_q <= 1'b0;
          if (accept) begin
            pc_q          <= end_atual;
            id_q          <= proc_id;
            fim_q         <= fim;
            state_q       <= SALVA;
            ctx_ocupado_q <= 1'b1;
          end
        end
        SALVA: begin
          slot_q[id_q]        <= pc_q;
          slot_valido_q[id_q] <= 1'b1;
          if (fim_q) proc_fim_q[id_q] <= 1'b1;
          ctx_pronto_q        <= 1'b1;
          state_q             <= PRONTO;
        end
        PRONTO: begin
          ctx_pronto_q  <= 1'b0;
          ctx_ocupado_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: begin
          ctx_pronto_q  <= 1'b0;
          ctx_ocupado_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign saida_pc    = (32'(proc_sel) < NUM_PROC) ? slot_q[proc_sel] : '0;
  assign slot_valido = slot_valido_q;
  assign proc_fim    = proc_fim_q;
  assign ctx_pronto  = ctx_pronto_q;
  assign ctx_ocupado = ctx_ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dados_ctx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_dados_ctx : randomized + directed bench with behavioural model |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_dados_ctx;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NP  = 4;
  localparam int OSL = 687;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_write, mem_read, troca, fim;
  logic [31:0]   posicao;
  logic [DW-1:0] dados, pos_atual, end_atual;
  logic [1:0]    proc_id, proc_sel;
  logic [DW-1:0] rd_data, saida_pc;
  logic          rd_valid, addr_err, ctx_ocupado, ctx_pronto;
  logic [NP-1:0] slot_valido, proc_fim;

  always #5 clk = ~clk;

  mem_dados_ctx #(.DATA_W(DW), .ADDR_W(AW), .NUM_PROC(NP), .OS_LIMIT(OSL)) dut (
    .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
    .posicao(posicao), .dados(dados), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err), .pos_atual(pos_atual), .end_atual(end_atual),
    .proc_id(proc_id), .troca(troca), .fim(fim), .proc_sel(proc_sel),
    .saida_pc(saida_pc), .slot_valido(slot_valido), .proc_fim(proc_fim),
    .ctx_ocupado(ctx_ocupado), .ctx_pronto(ctx_pronto)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: memory image plus a timeline of accepted saves.
  logic [DW-1:0] mem_m   [64];
  bit            known_m [64];
  logic [DW-1:0] exp_rd;
  bit            exp_rd_known, exp_rv, exp_err, exp_ocup, exp_pronto;
  logic [DW-1:0] slots_m [NP];
  logic [NP-1:0] sv_m, pf_m;
  int            cyc, acc_cyc;
  int            p_id;
  logic [DW-1:0] p_pc;
  bit            p_fim;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    mem_write = 0; mem_read = 0; posicao = 0; dados = 0;
    troca = 0; fim = 0; pos_atual = 0; end_atual = 0; proc_id = 0; proc_sel = 0;
  endtask

  task automatic model_reset();
    exp_rd = '0; exp_rd_known = 1; exp_rv = 0; exp_err = 0;
    exp_ocup = 0; exp_pronto = 0;
    for (int i = 0; i < NP; i++) slots_m[i] = '0;
    sv_m = '0; pf_m = '0;
    cyc = 0; acc_cyc = -100;
  endtask

  task automatic model_edge();
    bit ok, req;
    int idx;
    cyc++;
    ok  = (posicao < 32'd64);
    idx = int'(posicao[5:0]);
    exp_err = (mem_read || mem_write) && !ok;
    exp_rv  = mem_read && ok;
    if (mem_read && ok) begin
      if (mem_write) begin exp_rd = dados; exp_rd_known = 1; end
      else begin exp_rd = mem_m[idx]; exp_rd_known = known_m[idx]; end
    end
    if (mem_write && ok) begin mem_m[idx] = dados; known_m[idx] = 1; end
    if (cyc == acc_cyc + 1) begin
      slots_m[p_id] = p_pc;
      sv_m[p_id] = 1'b1;
      if (p_fim) pf_m[p_id] = 1'b1;
    end
    req = fim || (troca && (pos_atual > DW'(OSL)));
    if (req && (cyc - acc_cyc >= 3) && (int'(proc_id) < NP)) begin
      acc_cyc = cyc; p_id = int'(proc_id); p_pc = end_atual; p_fim = fim;
    end
    exp_ocup   = (cyc - acc_cyc) <= 1;
    exp_pronto = (cyc - acc_cyc) == 1;
  endtask

  task automatic check_all();
    chk("rd_valid", rd_valid, exp_rv);
    chk("addr_err", addr_err, exp_err);
    if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
    chk("ctx_ocupado", ctx_ocupado, exp_ocup);
    chk("ctx_pronto", ctx_pronto, exp_pronto);
    chk("slot_valido", slot_valido, sv_m);
    chk("proc_fim", proc_fim, pf_m);
    chk("saida_pc", saida_pc, slots_m[proc_sel]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) known_m[i] = 0;
    idle_in();
    do_reset();
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset ctx_ocupado", ctx_ocupado, 32'h0);

    // write then read back
    mem_write = 1; posicao = 5; dados = 32'hDEADBEEF; step();
    mem_write = 0; mem_read = 1; step();
    chk("rd 5 data", rd_data, 32'hDEADBEEF);
    chk("rd 5 valid", rd_valid, 32'h1);
    chk("rd 5 err", addr_err, 32'h0);

    // write-first on same index
    mem_write = 1; mem_read = 1; posicao = 63; dados = 32'h1234; step();
    chk("wf 63 data", rd_data, 32'h1234);

    // out-of-range write must not alias onto index 0
    mem_read = 0; posicao = 0; dados = 32'h11110000; step();
    posicao = 64; dados = 32'hFFFF; step();
    chk("oob err", addr_err, 32'h1);
    mem_write = 0; mem_read = 1; posicao = 0; step();
    chk("mem0 kept", rd_data, 32'h11110000);
    chk("mem0 err", addr_err, 32'h0);
    idle_in();

    // context switch outside OS region
    troca = 1; pos_atual = 700; end_atual = 32'h2C0; proc_id = 2; proc_sel = 2; step();
    chk("sw2 busy", ctx_ocupado, 32'h1);
    troca = 0; step();
    chk("sw2 slot", saida_pc, 32'h2C0);
    chk("sw2 valid", slot_valido, 32'h4);
    chk("sw2 pronto", ctx_pronto, 32'h1);
    chk("sw2 fim", proc_fim, 32'h0);
    step();
    chk("sw2 pronto off", ctx_pronto, 32'h0);

    // boundary: pos_atual == OS_LIMIT is still OS
    troca = 1; pos_atual = 687; end_atual = 32'h777; proc_id = 0; step();
    chk("os boundary busy", ctx_ocupado, 32'h0);
    idle_in(); step();

    // program end plus a dropped follow-up request
    fim = 1; proc_id = 1; end_atual = 32'h300; proc_sel = 1; step();
    fim = 0; troca = 1; pos_atual = 800; proc_id = 3; end_atual = 32'h999; step();
    chk("fim1 slot", saida_pc, 32'h300);
    chk("fim1 pf", proc_fim, 32'h2);
    idle_in(); proc_sel = 3; step();
    chk("drop slot3", saida_pc, 32'h0);
    step();
    chk("drop valid", slot_valido, 32'h6);
    chk("drop busy", ctx_ocupado, 32'h0);

    // reset in the middle of a save
    fim = 1; proc_id = 0; end_atual = 32'h55; proc_sel = 0; step();
    chk("mid busy", ctx_ocupado, 32'h1);
    rst_n = 0; idle_in(); model_reset();
    #1;
    chk("mid rst busy", ctx_ocupado, 32'h0);
    chk("mid rst valid", slot_valido, 32'h0);
    chk("mid rst slot0", saida_pc, 32'h0);
    check_all();
    @(posedge clk); #1; rst_n = 1;
    step(); step();
    chk("mid rst no pronto", ctx_pronto, 32'h0);
    chk("mid rst valid2", slot_valido, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      mem_write = 1'($urandom_range(0, 1));
      mem_read  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       posicao = $urandom;
        1:       posicao = 32'($urandom_range(64, 130));
        default: posicao = 32'($urandom_range(0, 63));
      endcase
      dados     = $urandom;
      troca     = ($urandom_range(0, 3) == 0);
      fim       = ($urandom_range(0, 7) == 0);
      pos_atual = ($urandom_range(0, 4) == 0) ? $urandom : DW'($urandom_range(680, 700));
      end_atual = $urandom;
      proc_id   = 2'($urandom_range(0, 3));
      proc_sel  = 2'($urandom_range(0, 3));
      step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
